// File: rtl/mc_ctrl_defs_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encodings,
// opcodes, mux-select encodings and the packed control word. Optional macro: CTRL_BNE_EN.
package mc_ctrl_defs;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
`ifdef CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_word_t;

  function automatic logic is_branch_op(input logic [5:0] op);
`ifdef CTRL_BNE_EN
    return (op == OP_BEQ) || (op == OP_BNE);
`else
    return (op == OP_BEQ);
`endif
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control word decoder for the multi-cycle control FSM.
// Unlisted fields stay 0; unused encodings decode to an all-zero word.
module mc_ctrl_outdec
  import mc_ctrl_defs::*;
(
  input  logic [3:0] state,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state_t'(state))
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multi-cycle MIPS datapath (Moore, decoded by mc_ctrl_outdec).
// Optional macro CTRL_BNE_EN adds the BNE opcode and the branch_ne output.
//
//  state    | meaning
//  ---------+------------------------------------------------
//  FETCH    | read instruction, load IR, PC <= PC+4
//  DECODE   | read registers, branch target into ALUOut
//  MEMADR   | effective address A + imm
//  MEMRD    | data memory read at ALUOut
//  MEMWB    | write MDR to rt
//  MEMWR    | data memory write at ALUOut
//  EXEC     | R-type ALU operation
//  ALUWB    | write ALUOut to rd
//  BRANCH   | compare A-B, conditional PC <= ALUOut
//  JUMP     | PC <= jump target
//  ADDI_EX  | A + imm
//  ADDI_WB  | write ALUOut to rt
module mc_control_fsm
  import mc_ctrl_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
`ifdef CTRL_BNE_EN
  ,
  output logic       branch_ne
`endif
);

  state_t     state_q;
  state_t     state_next;
  logic       illegal_dec;
  ctrl_word_t ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next  = S_FETCH;
    illegal_dec = 1'b0;
    case (state_q)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_next = S_MEMADR;
        else if (opcode == OP_RTYPE)                state_next = S_EXEC;
        else if (is_branch_op(opcode))              state_next = S_BRANCH;
        else if (opcode == OP_J)                    state_next = S_JUMP;
        else if (opcode == OP_ADDI)                 state_next = S_ADDI_EX;
        else begin
          state_next  = S_FETCH;
          illegal_dec = 1'b1;
        end
      end
      S_MEMADR:  state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = S_MEMWB;
      S_EXEC:    state_next = S_ALUWB;
      S_ADDI_EX: state_next = S_ADDI_WB;
      default:   state_next = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // Write enables are gated by reset so an aborted instruction cannot commit.
  assign pc_write      = ctrl.pc_write      & ~reset;
  assign pc_write_cond = ctrl.pc_write_cond & ~reset;
  assign mem_write     = ctrl.mem_write     & ~reset;
  assign reg_write     = ctrl.reg_write     & ~reset;
  assign ir_write      = ctrl.ir_write      & ~reset;
  assign instr_done    = (ctrl.instr_done | illegal_dec) & ~reset;
  assign illegal_op    = illegal_dec & ~reset;

  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_dst    = ctrl.reg_dst;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign state      = state_q;

`ifdef CTRL_BNE_EN
  // Remember BNE at decode so the opcode is not re-sampled in BRANCH.
  logic bne_q;

  always_ff @(posedge clk) begin
    if (reset)                     bne_q <= 1'b0;
    else if (state_q == S_DECODE)  bne_q <= (opcode == OP_BNE);
  end

  assign branch_ne = (state_q == S_BRANCH) && bne_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the stimulus pushes hand-derived expected
// control words per cycle; a monitor pops and compares at each falling edge.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
`ifdef CTRL_BNE_EN
  logic       branch_ne;
`endif

  mc_control_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .state         (state)
`ifdef CTRL_BNE_EN
    ,
    .branch_ne     (branch_ne)
`endif
  );

  always #5 clk = ~clk;

  // {pc_write,pc_write_cond,iord,mem_read,mem_write,ir_write,mem_to_reg,
  //  reg_dst,reg_write,alu_src_a,alu_src_b,alu_op,pc_source,instr_done}
  logic [16:0] exp_tbl [16] = '{
    17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0,  // FETCH
    17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0,  // DECODE
    17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0,  // MEMADR
    17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0,  // MEMRD
    17'b0_0_0_0_0_0_1_0_1_0_00_00_00_1,  // MEMWB
    17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1,  // MEMWR
    17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0,  // EXEC
    17'b0_0_0_0_0_0_0_1_1_0_00_00_00_1,  // ALUWB
    17'b0_1_0_0_0_0_0_0_0_1_00_01_01_1,  // BRANCH
    17'b1_0_0_0_0_0_0_0_0_0_00_00_10_1,  // JUMP
    17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0,  // ADDI_EX
    17'b0_0_0_0_0_0_0_0_1_0_00_00_00_1,  // ADDI_WB
    17'b0, 17'b0, 17'b0, 17'b0
  };
  localparam logic [16:0] RST_MASK = 17'b0_0_1_1_0_0_1_1_0_1_11_11_11_0;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic        ill;
    logic        bne;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_cycle  = 0;

  task automatic step(input logic rst, input logic [5:0] op, input logic [3:0] st,
                      input logic ill, input logic bne);
    exp_t e;
    reset  = rst;
    opcode = op;
    e.st   = st;
    e.ctrl = exp_tbl[st];
    if (ill) e.ctrl[0] = 1'b1;
    e.ill  = ill;
    if (rst) begin
      e.ctrl = e.ctrl & RST_MASK;
      e.ill  = 1'b0;
    end
    e.bne = bne;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [16:0] act;
      e   = exp_q.pop_front();
      act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done};
      n_cycle++;
      n_checks++;
      if (state !== e.st) begin
        n_errors++;
        $display("FAIL state cyc=%0d: got %0d expected %0d", n_cycle, state, e.st);
      end
      n_checks++;
      if (act !== e.ctrl) begin
        n_errors++;
        $display("FAIL ctrl cyc=%0d state=%0d: got %b expected %b", n_cycle, e.st, act, e.ctrl);
      end
      n_checks++;
      if (illegal_op !== e.ill) begin
        n_errors++;
        $display("FAIL illegal_op cyc=%0d: got %b expected %b", n_cycle, illegal_op, e.ill);
      end
`ifdef CTRL_BNE_EN
      n_checks++;
      if (branch_ne !== e.bne) begin
        n_errors++;
        $display("FAIL branch_ne cyc=%0d: got %b expected %b", n_cycle, branch_ne, e.bne);
      end
`endif
    end
  end

  initial begin
    reset  = 1'b1;
    opcode = 6'h00;
    @(posedge clk);
    #1;
    // reset held 3 cycles
    repeat (3) step(1'b1, 6'h00, 4'd0, 1'b0, 1'b0);
    // LW
    step(0, 6'h23, 4'd0, 0, 0);
    step(0, 6'h23, 4'd1, 0, 0);
    step(0, 6'h23, 4'd2, 0, 0);
    step(0, 6'h23, 4'd3, 0, 0);
    step(0, 6'h23, 4'd4, 0, 0);
    // SW
    step(0, 6'h2B, 4'd0, 0, 0);
    step(0, 6'h2B, 4'd1, 0, 0);
    step(0, 6'h2B, 4'd2, 0, 0);
    step(0, 6'h2B, 4'd5, 0, 0);
    // BEQ
    step(0, 6'h04, 4'd0, 0, 0);
    step(0, 6'h04, 4'd1, 0, 0);
    step(0, 6'h04, 4'd8, 0, 0);
    // J
    step(0, 6'h02, 4'd0, 0, 0);
    step(0, 6'h02, 4'd1, 0, 0);
    step(0, 6'h02, 4'd9, 0, 0);
    // ADDI
    step(0, 6'h08, 4'd0, 0, 0);
    step(0, 6'h08, 4'd1, 0, 0);
    step(0, 6'h08, 4'd10, 0, 0);
    step(0, 6'h08, 4'd11, 0, 0);
    // illegal opcode
    step(0, 6'h3F, 4'd0, 0, 0);
    step(0, 6'h3F, 4'd1, 1, 0);
    // opcode 0x05: BNE when enabled, otherwise illegal
    step(0, 6'h05, 4'd0, 0, 0);
`ifdef CTRL_BNE_EN
    step(0, 6'h05, 4'd1, 0, 0);
    step(0, 6'h05, 4'd8, 0, 1);
`else
    step(0, 6'h05, 4'd1, 1, 0);
`endif
    // R-type aborted by reset in EXEC
    step(0, 6'h00, 4'd0, 0, 0);
    step(0, 6'h00, 4'd1, 0, 0);
    step(1, 6'h00, 4'd6, 0, 0);
    // full R-type afterwards
    step(0, 6'h00, 4'd0, 0, 0);
    step(0, 6'h00, 4'd1, 0, 0);
    step(0, 6'h00, 4'd6, 0, 0);
    step(0, 6'h00, 4'd7, 0, 0);
    step(0, 6'h2B, 4'd0, 0, 0);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
